bram_prog_loader: RTL
=====================

Name: bram_prog_loader

Overview:
- Sequences the AXI4-Lite write channel of the program BRAM (axi_bram_ctrl_0).
- Accepts a little-endian byte stream, packs it into 32-bit words and writes them to consecutive word addresses from BASE_ADDR.
- Appends a terminator word after the last program word, then raises cpu_start to release the control unit.
- Replaces the hand-sequenced AW/W/B load loop currently done in benches, and also serves the hardware boot path.

Parameters:
- ADDR_W, 20, AXI byte-address width; matches the BRAM controller.
- BASE_ADDR, 0, byte address of the first program word; must be 4-aligned.
- MAX_WORDS, 88, program capacity in words, excluding the terminator.
- TERM_WORD, 32'hFFFF_FFFF, word written immediately after the program.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle pulse; starts a load; sampled only in IDLE or DONE
- in_valid  in  1  byte-stream valid
- in_ready  out  1  byte-stream ready
- in_data  in  8  program byte
- in_last  in  1  marks the final byte of the program
- awvalid  out  1  AXI write-address valid
- awready  in  1  AXI write-address ready
- awaddr  out  ADDR_W  AXI write address
- wvalid  out  1  AXI write-data valid
- wready  in  1  AXI write-data ready
- wdata  out  32  AXI write data
- wstrb  out  4  AXI write strobes; constant 4'b1111
- bvalid  in  1  AXI write-response valid
- bready  out  1  AXI write-response ready
- bresp  in  2  AXI write response
- busy  out  1  load in progress (COLLECT, WRITE or RESP)
- cpu_start  out  1  level; held high in DONE
- error  out  1  sticky error flag
- word_count  out  ADDR_W-2  number of program words accepted by BRAM (OKAY response), terminator excluded

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, except wstrb=4'b1111 and awaddr=BASE_ADDR. Byte lane index, pack register and word_count cleared.
- Reset asserted mid-transaction drops valids immediately. Accepted because the BRAM controller shares the same reset.
- IDLE: in_ready=0. On go: go to COLLECT; clear error, word_count and lane index; awaddr=BASE_ADDR.
- COLLECT: in_ready=1.
  - Each in_valid&in_ready stores in_data into byte lane [8*lane+:8] of the pack register; lane increments.
  - Lane 3 accepted, or in_last accepted: go to WRITE with wdata = packed word. Unfilled upper lanes are zero.
  - A lone in_last with no other bytes gives a 1-word program.
  - If word_count==MAX_WORDS and a byte handshakes: go to ERR. That byte is consumed and nothing is written.
- WRITE: in_ready=0.
  - awvalid and wvalid rise together in the first WRITE cycle.
  - Each valid drops on its own handshake cycle (valid&ready). Once a valid drops it is not re-raised within that beat.
  - When both handshakes are done (same or different cycles): go to RESP.
  - awaddr and wdata hold stable while the corresponding valid is high.
- RESP: bready=1. On bvalid:
  - bresp==2'b00: if the word was a program word, increment word_count and advance awaddr by 4.
    - If that program word was not the last: return to COLLECT with lane=0.
    - If it was the last: load TERM_WORD into wdata and go to WRITE with term_flag=1.
    - If the word was the terminator: go to DONE.
  - bresp!=2'b00: go to ERR.
- Latency: minimum 1 WRITE + 1 RESP cycle per word with zero-wait slave. Word 0 is written at BASE_ADDR, the terminator at BASE_ADDR+4*word_count.
- DONE: cpu_start=1, busy=0. go clears cpu_start and restarts the load (COLLECT).
- ERR: error=1 (sticky), busy=0, cpu_start=0, all valids 0. Leaves only on go (restart) or reset.
- go while busy is ignored. in_last arriving when lane index is 3 on the same byte counts as a full word.
- word_count never exceeds MAX_WORDS.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], cleared on go.
  - Accumulates (mod 2^32) every program word that receives an OKAY response; the terminator is excluded.
  - Valid when cpu_start=1.
- Undefined: the port and accumulator are absent; behaviour otherwise identical.

Test Plan:
- Bytes 01..08 with in_last on 08, zero-wait slave:
  - writes 0x04030201@0x0, 0x08070605@0x4, 0xFFFFFFFF@0x8;
  - word_count=2, cpu_start=1;
  - with LOADER_CHECKSUM_EN: checksum=0x0C0A0806.
- 5 bytes AA BB CC DD EE (last on EE):
  - writes 0xDDCCBBAA@0x0, 0x000000EE@0x4, terminator@0x8;
  - word_count=2.
- awready delayed 3 cycles, wready immediate:
  - wvalid high exactly 1 cycle, awvalid held 4 cycles with stable awaddr;
  - single RESP follows; no duplicate write.
- bresp=2'b10 on second word:
  - error=1, word_count=1, no terminator write, cpu_start=0;
  - next go clears error and completes a good load.
- MAX_WORDS=2, stream of 12 bytes:
  - 2 words written, 9th byte gives error=1, no terminator.
- rst_n pulsed low during RESP of word 1:
  - all outputs at reset values asynchronously;
  - fresh go then reloads correctly from BASE_ADDR.

Source files
------------

// File: rtl/bram_prog_loader.sv
// bram_prog_loader: packs a little-endian byte stream into 32-bit words, writes them plus a
// terminator word through an AXI4-Lite write channel, then raises cpu_start. Option: LOADER_CHECKSUM_EN.
`default_nettype none

module bram_prog_loader #(
    parameter int                ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 88,
    parameter logic [31:0]       TERM_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_data_i,
    input  logic              in_last_i,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [31:0]       wdata_o,
    output logic [3:0]        wstrb_o,
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i,
    output logic              busy_o,
    output logic              cpu_start_o,
    output logic              error_o,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       checksum_o,
`endif
    output logic [ADDR_W-3:0] word_count_o
);

    localparam logic [ADDR_W-3:0] MAX_WC = (ADDR_W-2)'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_RESP    = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t             state_q;
    logic [1:0]         lane_q;
    logic [31:0]        pack_q;
    logic [31:0]        pack_d;
    logic [31:0]        wdata_q;
    logic [ADDR_W-1:0]  awaddr_q;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic               in_ready_q;
    logic               term_q;
    logic               last_q;
    logic               busy_q;
    logic               cpu_start_q;
    logic               error_q;
    logic [ADDR_W-3:0]  word_count_q;

    logic w_start;
    logic w_resp_ok_prog;

    // Lanes not yet written keep the zeros loaded when collection of a word began.
    always_comb begin
        pack_d                  = pack_q;
        pack_d[8*lane_q +: 8]   = in_data_i;
    end

    assign w_start = go_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign w_resp_ok_prog = (state_q == S_RESP) && bvalid_i && bready_q &&
                            (bresp_i == 2'b00) && !term_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lane_q       <= 2'd0;
            pack_q       <= '0;
            wdata_q      <= '0;
            awaddr_q     <= BASE_ADDR;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            term_q       <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            cpu_start_q  <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_start) begin
                        state_q      <= S_COLLECT;
                        lane_q       <= 2'd0;
                        pack_q       <= '0;
                        awaddr_q     <= BASE_ADDR;
                        term_q       <= 1'b0;
                        last_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        cpu_start_q  <= 1'b0;
                        error_q      <= 1'b0;
                        word_count_q <= '0;
                        in_ready_q   <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (in_valid_i && in_ready_q) begin
                        if (word_count_q == MAX_WC) begin
                            // Capacity exhausted: the byte is swallowed and nothing is written.
                            state_q    <= S_ERR;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b0;
                        end else if (lane_q == 2'd3 || in_last_i) begin
                            state_q    <= S_WRITE;
                            wdata_q    <= pack_d;
                            last_q     <= in_last_i;
                            awvalid_q  <= 1'b1;
                            wvalid_q   <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            pack_q <= pack_d;
                            lane_q <= lane_q + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (awvalid_q && awready_i) awvalid_q <= 1'b0;
                    if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                        state_q  <= S_RESP;
                        bready_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bvalid_i && bready_q) begin
                        bready_q <= 1'b0;
                        if (bresp_i != 2'b00) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (term_q) begin
                            state_q     <= S_DONE;
                            cpu_start_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            word_count_q <= word_count_q + 1'b1;
                            awaddr_q     <= awaddr_q + ADDR_W'(4);
                            if (last_q) begin
                                state_q   <= S_WRITE;
                                wdata_q   <= TERM_WORD;
                                term_q    <= 1'b1;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                            end else begin
                                state_q    <= S_COLLECT;
                                lane_q     <= 2'd0;
                                pack_q     <= '0;
                                in_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (w_start) begin
            checksum_q <= '0;
        end else if (w_resp_ok_prog) begin
            checksum_q <= checksum_q + wdata_q;
        end
    end

    assign checksum_o = checksum_q;
`endif

    assign in_ready_o   = in_ready_q;
    assign awvalid_o    = awvalid_q;
    assign awaddr_o     = awaddr_q;
    assign wvalid_o     = wvalid_q;
    assign wdata_o      = wdata_q;
    assign wstrb_o      = 4'b1111;
    assign bready_o     = bready_q;
    assign busy_o       = busy_q;
    assign cpu_start_o  = cpu_start_q;
    assign error_o      = error_q;
    assign word_count_o = word_count_q;

    logic w_unused;
    assign w_unused = w_resp_ok_prog;

endmodule

`default_nettype wire
